// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI YUV422 capture path.
//   cap_state_e    : lock FSM states (SEEK, MEASURE)
//   ycbcr_t        : unpacked 24-bit pixel {y, cb, cr}
//   CHROMA_NEUTRAL : chroma value used when a sample has no Cr partner
package hdmi_pkg;

  typedef enum logic {
    SEEK,
    MEASURE
  } cap_state_e;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
  } ycbcr_t;

  localparam logic [7:0] CHROMA_NEUTRAL = 8'h80;

endpackage

// File: rtl/yuv422_unpack.sv
// Two-stage YUV422 -> YCbCr pairing pipeline.
// Ports:
//   clk_i, rst_i : pixel clock, synchronous active-high reset
//   de_i         : sample valid (already registered by the caller)
//   x0_i         : LSB of the sample's x position (0 = carries Cb, 1 = carries Cr)
//   d_i          : {Y, Cb/Cr} sample
//   pix_o        : {Y, Cb, Cr} pixel, two cycles after its sample
//   valid_o      : pix_o holds a pixel
module yuv422_unpack
  import hdmi_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        de_i,
  input  logic        x0_i,
  input  logic [15:0] d_i,
  output ycbcr_t      pix_o,
  output logic        valid_o
);

  logic        s1De_q;
  logic        s1X0_q;
  logic [15:0] s1D_q;
  logic [7:0]  cbHold_q;
  ycbcr_t      pix_q;
  logic        valid_q;

  // Stage 1 just delays the sample by one cycle so that, for an even
  // sample, its odd partner (carrying Cr) is visible on the inputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1De_q <= 1'b0;
      s1X0_q <= 1'b0;
      s1D_q  <= '0;
    end else begin
      s1De_q <= de_i;
      s1X0_q <= x0_i;
      s1D_q  <= d_i;
    end
  end

  // Stage 2 builds the pixel. An even sample takes Cr from the partner now
  // on the inputs (neutral chroma if the line ended on it) and remembers
  // its Cb; the following odd sample reuses that Cb and its own Cr, so both
  // pixels of a pair carry identical chroma.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      pix_q    <= '0;
      cbHold_q <= '0;
    end else begin
      valid_q <= s1De_q;
      if (s1De_q) begin
        if (!s1X0_q) begin
          pix_q    <= '{y: s1D_q[15:8], cb: s1D_q[7:0],
                        cr: (de_i && x0_i) ? d_i[7:0] : CHROMA_NEUTRAL};
          cbHold_q <= s1D_q[7:0];
        end else begin
          pix_q <= '{y: s1D_q[15:8], cb: cbHold_q, cr: s1D_q[7:0]};
        end
      end
    end
  end

  assign pix_o   = pix_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/hdmi_capture_yuv422.sv
// HDMI YUV422 capture: registers the incoming vs/hs/de/data stream, checks
// its timing against the parameters, tracks lock, unpacks to {Y,Cb,Cr},
// decimates and drives the framebuffer write port.
// Ports:
//   clk_i, rst_i       : pixel clock, synchronous active-high reset
//   vs_i, hs_i, de_i   : video syncs / data enable (sync polarity = SYNC_POLARITY)
//   d_i                : [15:8] Y, [7:0] Cb (even x) / Cr (odd x)
//   pxl_addr_o/_data_o : framebuffer write address / {Y,Cb,Cr}
//   pxl_en_o           : write strobe
//   locked_o           : LOCK_FRAMES consecutive good frames seen
//   err_o, frame_o     : bad-frame pulse, vs-edge pulse
// Optional macro CAPTURE_STATS_EN adds line_px_o, lines_o, frame_cnt_o and
// hs_err_o; without it hs_i is unused.
module hdmi_capture_yuv422
  import hdmi_pkg::*;
#(
  parameter int ACTIVE_H_PIXELS = 1280,
  parameter int ACTIVE_LINES    = 720,
  parameter int SYNC_POLARITY   = 0,
  parameter int FRAME_X_SCALE   = 0,
  parameter int FRAME_Y_SCALE   = 0,
  parameter int LOCK_FRAMES     = 2,
  localparam int FB_X         = ACTIVE_H_PIXELS >> FRAME_X_SCALE,
  localparam int FB_Y         = ACTIVE_LINES >> FRAME_Y_SCALE,
  localparam int FB_ADDR_BITS = $clog2(FB_X * FB_Y)
)(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    vs_i,
  input  logic                    hs_i,
  input  logic                    de_i,
  input  logic [15:0]             d_i,
  output logic [FB_ADDR_BITS-1:0] pxl_addr_o,
  output logic [23:0]             pxl_data_o,
  output logic                    pxl_en_o,
  output logic                    locked_o,
  output logic                    err_o,
  output logic                    frame_o
`ifdef CAPTURE_STATS_EN
  ,
  output logic [15:0]             line_px_o,
  output logic [15:0]             lines_o,
  output logic [31:0]             frame_cnt_o,
  output logic                    hs_err_o
`endif
);

  localparam logic        SYNC_ACTIVE = SYNC_POLARITY[0];
  localparam logic [15:0] H_PIX       = 16'(ACTIVE_H_PIXELS);
  localparam logic [15:0] V_LINES     = 16'(ACTIVE_LINES);
  localparam logic [15:0] X_MASK      = 16'((1 << FRAME_X_SCALE) - 1);
  localparam logic [15:0] Y_MASK      = 16'((1 << FRAME_Y_SCALE) - 1);
  localparam int          GC_BITS     = $clog2(LOCK_FRAMES + 1);
  localparam logic [GC_BITS-1:0]      LOCK_N   = GC_BITS'(LOCK_FRAMES);
  localparam logic [FB_ADDR_BITS-1:0] ADDR_MAX = FB_ADDR_BITS'(FB_X * FB_Y - 1);

  logic        vsAct_q, vsActPrev_q, de_q, dePrev_q;
  logic [15:0] d_q;
  logic        vsEdge, deRise, deFall;

  // Single input register stage; vs is stored as "active" so the edge
  // detector does not care about polarity.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vsAct_q     <= 1'b0;
      vsActPrev_q <= 1'b0;
      de_q        <= 1'b0;
      dePrev_q    <= 1'b0;
      d_q         <= '0;
    end else begin
      vsAct_q     <= (vs_i == SYNC_ACTIVE);
      vsActPrev_q <= vsAct_q;
      de_q        <= de_i;
      dePrev_q    <= de_q;
      d_q         <= d_i;
    end
  end

  assign vsEdge = vsAct_q & ~vsActPrev_q;
  assign deRise = de_q & ~dePrev_q;
  assign deFall = ~de_q & dePrev_q;

  logic [15:0] xCount_q, yCount_q;
  logic        lineBad_q;

  // x is the index of the sample now in d_q (it sits at 0 while de is low);
  // y counts lines started this frame. A wrong-width line is remembered
  // until the frame is judged at the next vs edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      xCount_q  <= '0;
      yCount_q  <= '0;
      lineBad_q <= 1'b0;
    end else if (vsEdge) begin
      xCount_q  <= '0;
      yCount_q  <= '0;
      lineBad_q <= 1'b0;
    end else begin
      if (de_q) begin
        if (xCount_q != 16'hFFFF) xCount_q <= xCount_q + 16'd1;
      end else begin
        xCount_q <= '0;
      end
      if (deRise && yCount_q != 16'hFFFF) yCount_q <= yCount_q + 16'd1;
      if (deFall && xCount_q != H_PIX) lineBad_q <= 1'b1;
    end
  end

  logic [15:0] yCur;
  logic        frameGood, keepIn;
  cap_state_e  state_q;
  logic [GC_BITS-1:0] goodCnt_q, goodCnt_d;
  logic        locked_q, locked_d, err_q, frame_q, wrArm_q, evalBad;

  // A line whose de falls in the same cycle as the vs edge still has its
  // width checked here, since the counter block never gets to latch it.
  assign frameGood = ~lineBad_q & ~(deFall & (xCount_q != H_PIX)) &
                     (yCount_q == V_LINES) & ~de_q;

  // On its first cycle a line's y count has not been bumped yet.
  assign yCur   = deRise ? yCount_q : yCount_q - 16'd1;
  assign keepIn = wrArm_q & de_q & (xCount_q < H_PIX) & (yCur < V_LINES) &
                  ((xCount_q & X_MASK) == 16'd0) & ((yCur & Y_MASK) == 16'd0);

  // Next lock state for the frame just finished. Only MEASURE judges
  // frames: the edge that leaves SEEK merely opens the first one.
  always_comb begin
    goodCnt_d = goodCnt_q;
    locked_d  = locked_q;
    evalBad   = 1'b0;
    if (vsEdge && state_q == MEASURE) begin
      if (frameGood) begin
        goodCnt_d = (goodCnt_q == LOCK_N) ? goodCnt_q : goodCnt_q + 1'b1;
        locked_d  = (goodCnt_d == LOCK_N);
      end else begin
        goodCnt_d = '0;
        locked_d  = 1'b0;
        evalBad   = 1'b1;
      end
    end
  end

  // Lock FSM with registered pulses. Write enable for the coming frame is
  // taken from the lock result decided on this same edge and held until the
  // next edge, so a frame is written only if lock held as it began.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= SEEK;
      goodCnt_q <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      frame_q   <= 1'b0;
      wrArm_q   <= 1'b0;
    end else begin
      frame_q   <= vsEdge;
      err_q     <= evalBad;
      goodCnt_q <= goodCnt_d;
      locked_q  <= locked_d;
      if (vsEdge) wrArm_q <= locked_d;
      case (state_q)
        SEEK:    if (vsEdge) state_q <= MEASURE;
        MEASURE: state_q <= MEASURE;
        default: state_q <= SEEK;
      endcase
    end
  end

  logic [FB_ADDR_BITS-1:0] addrCnt_q, addr1_q, addr2_q;
  logic                    keep1_q, keep2_q;

  // The write address is handed out when a sample is accepted and then
  // travels with it, so pixels already in flight at a vs edge keep their
  // old-frame addresses while the counter restarts. The counter sticks at
  // the last framebuffer slot instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addrCnt_q <= '0;
      addr1_q   <= '0;
      addr2_q   <= '0;
      keep1_q   <= 1'b0;
      keep2_q   <= 1'b0;
    end else begin
      keep1_q <= keepIn;
      addr1_q <= addrCnt_q;
      keep2_q <= keep1_q;
      addr2_q <= addr1_q;
      if (vsEdge) addrCnt_q <= '0;
      else if (keepIn && addrCnt_q != ADDR_MAX) addrCnt_q <= addrCnt_q + 1'b1;
    end
  end

  ycbcr_t unpackPix;
  logic   unpackValid;

  yuv422_unpack u_unpack (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .de_i    (de_q),
    .x0_i    (xCount_q[0]),
    .d_i     (d_q),
    .pix_o   (unpackPix),
    .valid_o (unpackValid)
  );

  assign pxl_addr_o = addr2_q;
  assign pxl_data_o = unpackPix;
  assign pxl_en_o   = keep2_q & unpackValid;
  assign locked_o   = locked_q;
  assign err_o      = err_q;
  assign frame_o    = frame_q;

`ifdef CAPTURE_STATS_EN
  logic        hsAct_q, hsErr_q;
  logic [15:0] lastWidth_q, linePx_q, lines_q;
  logic [31:0] frameCnt_q;

  // Timing statistics, published on each vs edge; hs during active data
  // is a sticky error until reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hsAct_q     <= 1'b0;
      hsErr_q     <= 1'b0;
      lastWidth_q <= '0;
      linePx_q    <= '0;
      lines_q     <= '0;
      frameCnt_q  <= '0;
    end else begin
      hsAct_q <= (hs_i == SYNC_ACTIVE);
      if (hsAct_q && de_q) hsErr_q <= 1'b1;
      if (deFall) lastWidth_q <= xCount_q;
      if (vsEdge) begin
        linePx_q   <= deFall ? xCount_q : lastWidth_q;
        lines_q    <= yCount_q;
        frameCnt_q <= frameCnt_q + 32'd1;
      end
    end
  end

  assign line_px_o   = linePx_q;
  assign lines_o     = lines_q;
  assign frame_cnt_o = frameCnt_q;
  assign hs_err_o    = hsErr_q;
`else
  logic unusedHs;
  assign unusedHs = hs_i;
`endif

endmodule

// File: tb/tb_hdmi_capture_yuv422.sv
module tb_hdmi_capture_yuv422;

  localparam int H = 16;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst, vs, hs, de;
  logic [15:0] d;

  logic [5:0]  addrA;
  logic [23:0] dataA;
  logic        enA, lockA, errA, frameA;
  logic [3:0]  addrB;
  logic [23:0] dataB;
  logic        enB, lockB, errB, frameB;

`ifdef CAPTURE_STATS_EN
  logic [15:0] linePxA, linesA, linePxB, linesB;
  logic [31:0] frameCntA, frameCntB;
  logic        hsErrA, hsErrB;
`endif

  // Full-resolution instance
  hdmi_capture_yuv422 #(
    .ACTIVE_H_PIXELS(H), .ACTIVE_LINES(L), .SYNC_POLARITY(0),
    .FRAME_X_SCALE(0), .FRAME_Y_SCALE(0), .LOCK_FRAMES(2)
  ) dutA (
    .clk_i(clk), .rst_i(rst), .vs_i(vs), .hs_i(hs), .de_i(de), .d_i(d),
    .pxl_addr_o(addrA), .pxl_data_o(dataA), .pxl_en_o(enA),
    .locked_o(lockA), .err_o(errA), .frame_o(frameA)
`ifdef CAPTURE_STATS_EN
    , .line_px_o(linePxA), .lines_o(linesA), .frame_cnt_o(frameCntA), .hs_err_o(hsErrA)
`endif
  );

  // 2x2 decimating instance sharing the same input stream
  hdmi_capture_yuv422 #(
    .ACTIVE_H_PIXELS(H), .ACTIVE_LINES(L), .SYNC_POLARITY(0),
    .FRAME_X_SCALE(1), .FRAME_Y_SCALE(1), .LOCK_FRAMES(2)
  ) dutB (
    .clk_i(clk), .rst_i(rst), .vs_i(vs), .hs_i(hs), .de_i(de), .d_i(d),
    .pxl_addr_o(addrB), .pxl_data_o(dataB), .pxl_en_o(enB),
    .locked_o(lockB), .err_o(errB), .frame_o(frameB)
`ifdef CAPTURE_STATS_EN
    , .line_px_o(linePxB), .lines_o(linesB), .frame_cnt_o(frameCntB), .hs_err_o(hsErrB)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [23:0] data;
    int          cyc;
  } exp_t;

  exp_t qA[$];
  exp_t qB[$];

  int cyc = 0;
  int checksTotal = 0;
  int checksPassed = 0;
  int mAddrA, mAddrB;
  int wrCntA, wrCntB;
  int frameCntPulseA = 0, errCntPulseA = 0, errCntPulseB = 0;
  logic [23:0] dataAt0A, dataAt1A;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboards and counts pulses
  always @(negedge clk) begin
    exp_t e;
    if (frameA) frameCntPulseA++;
    if (errA) errCntPulseA++;
    if (errB) errCntPulseB++;
    if (errA) begin
      checksTotal++;
      if (frameA !== 1'b1) $display("[TB] FAIL err_frame_align: err_o=1 frame_o=%b required frame_o=1", frameA);
      else checksPassed++;
    end
    if (enA) begin
      wrCntA++;
      if (addrA == 6'd0) dataAt0A = dataA;
      if (addrA == 6'd1) dataAt1A = dataA;
      checksTotal++;
      if (qA.size() == 0) begin
        $display("[TB] FAIL wrA_unexpected: addr=%0d data=%h required no write", addrA, dataA);
      end else begin
        e = qA.pop_front();
        if (int'(addrA) !== e.addr || dataA !== e.data || cyc !== e.cyc)
          $display("[TB] FAIL wrA: addr=%0d data=%h cyc=%0d required addr=%0d data=%h cyc=%0d",
                   addrA, dataA, cyc, e.addr, e.data, e.cyc);
        else checksPassed++;
      end
    end
    if (enB) begin
      wrCntB++;
      checksTotal++;
      if (qB.size() == 0) begin
        $display("[TB] FAIL wrB_unexpected: addr=%0d data=%h required no write", addrB, dataB);
      end else begin
        e = qB.pop_front();
        if (int'(addrB) !== e.addr || dataB !== e.data || cyc !== e.cyc)
          $display("[TB] FAIL wrB: addr=%0d data=%h cyc=%0d required addr=%0d data=%h cyc=%0d",
                   addrB, dataB, cyc, e.addr, e.data, e.cyc);
        else checksPassed++;
      end
    end
  end

  // Expected pixel i of a line of n samples
  function automatic logic [23:0] pixOf(input logic [15:0] s[16], input int n, input int i);
    int e;
    logic [7:0] cr;
    e = i - (i % 2);
    cr = (e + 1 < n) ? s[e + 1][7:0] : 8'h80;
    return {s[i][15:8], s[e][7:0], cr};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      de = 1'b0;
      d  = 16'h0000;
    end
  endtask

  // One line of samples; expectations are queued only for x < pushLimit
  task automatic sendLine(input int y, input int width, input bit armed,
                          input bit special, input int pushLimit);
    logic [15:0] s[16];
    exp_t e;
    for (int x = 0; x < 16; x++) s[x] = {8'(y * 32 + x), 8'(x * 2 + 1 + y * 8)};
    if (special) begin
      s[0] = 16'h0A14;
      s[1] = 16'h0B1E;
    end
    for (int x = 0; x < width; x++) begin
      @(negedge clk);
      de = 1'b1;
      d  = s[x];
      if (armed && x < pushLimit) begin
        e.data = pixOf(s, width, x);
        e.cyc  = cyc + 3;
        e.addr = mAddrA;
        qA.push_back(e);
        if (mAddrA < 63) mAddrA++;
        if (x % 2 == 0 && y % 2 == 0) begin
          e.addr = mAddrB;
          qB.push_back(e);
          if (mAddrB < 15) mAddrB++;
        end
      end
    end
  endtask

  task automatic sendVs();
    idle(2);
    repeat (2) begin @(negedge clk); vs = 1'b0; end
    repeat (3) begin @(negedge clk); vs = 1'b1; end
  endtask

  // A full frame followed by its closing vs pulse, then the per-frame checks
  task automatic sendFrame(input bit armed, input int shortLine, input bit special,
                           input bit expLock, input bit expErr, input string name);
    int f0, eA0, eB0, expWrA, expWrB;
    f0 = frameCntPulseA; eA0 = errCntPulseA; eB0 = errCntPulseB;
    wrCntA = 0; wrCntB = 0; mAddrA = 0; mAddrB = 0;
    expWrA = 0;
    for (int y = 0; y < L; y++) begin
      int w;
      w = (y == shortLine) ? H - 1 : H;
      if (armed) expWrA += w;
      idle(3);
      sendLine(y, w, armed, special && y == 0, 16);
    end
    expWrB = armed ? 16 : 0;
    sendVs();
    checksTotal++;
    if (frameCntPulseA - f0 !== 1) $display("[TB] FAIL %s frame_pulses: got %0d required 1", name, frameCntPulseA - f0);
    else checksPassed++;
    checksTotal++;
    if (errCntPulseA - eA0 !== int'(expErr)) $display("[TB] FAIL %s errA: got %0d required %0d", name, errCntPulseA - eA0, expErr);
    else checksPassed++;
    checksTotal++;
    if (errCntPulseB - eB0 !== int'(expErr)) $display("[TB] FAIL %s errB: got %0d required %0d", name, errCntPulseB - eB0, expErr);
    else checksPassed++;
    checksTotal++;
    if (lockA !== expLock) $display("[TB] FAIL %s lockA: got %b required %b", name, lockA, expLock);
    else checksPassed++;
    checksTotal++;
    if (lockB !== expLock) $display("[TB] FAIL %s lockB: got %b required %b", name, lockB, expLock);
    else checksPassed++;
    checksTotal++;
    if (wrCntA !== expWrA) $display("[TB] FAIL %s wrcountA: got %0d required %0d", name, wrCntA, expWrA);
    else checksPassed++;
    checksTotal++;
    if (wrCntB !== expWrB) $display("[TB] FAIL %s wrcountB: got %0d required %0d", name, wrCntB, expWrB);
    else checksPassed++;
    checksTotal++;
    if (qA.size() != 0 || qB.size() != 0) $display("[TB] FAIL %s missing_writes: pendingA=%0d pendingB=%0d required 0", name, qA.size(), qB.size());
    else checksPassed++;
    qA.delete();
    qB.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; vs = 1'b1; hs = 1'b1; de = 1'b0; d = 16'h0000;
    repeat (3) @(negedge clk);
    checksTotal++;
    if ({enA, lockA, errA, frameA} !== 4'b0000) $display("[TB] FAIL reset_ctrlA: got %b required 0000", {enA, lockA, errA, frameA});
    else checksPassed++;
    checksTotal++;
    if (addrA !== 6'd0 || dataA !== 24'h0) $display("[TB] FAIL reset_busA: addr=%0d data=%h required 0", addrA, dataA);
    else checksPassed++;
    checksTotal++;
    if ({enB, lockB, errB, frameB} !== 4'b0000) $display("[TB] FAIL reset_ctrlB: got %b required 0000", {enB, lockB, errB, frameB});
    else checksPassed++;
    rst = 1'b0;
    idle(4);
  endtask

  task automatic test_lock_acquire();
    sendFrame(1'b0, -1, 1'b0, 1'b0, 1'b0, "lock_f1");
    sendFrame(1'b0, -1, 1'b0, 1'b0, 1'b0, "lock_f2");
    sendFrame(1'b0, -1, 1'b0, 1'b1, 1'b0, "lock_f3");
  endtask

  task automatic test_capture();
    sendFrame(1'b1, -1, 1'b1, 1'b1, 1'b0, "capture_f4");
    checksTotal++;
    if (dataAt0A !== 24'h0A141E) $display("[TB] FAIL capture_pix0: got %h required 0a141e", dataAt0A);
    else checksPassed++;
    checksTotal++;
    if (dataAt1A !== 24'h0B141E) $display("[TB] FAIL capture_pix1: got %h required 0b141e", dataAt1A);
    else checksPassed++;
  endtask

  task automatic test_bad_line();
    sendFrame(1'b1, 1, 1'b0, 1'b0, 1'b1, "bad_f5");
    sendFrame(1'b0, -1, 1'b0, 1'b0, 1'b0, "bad_f6");
    sendFrame(1'b0, -1, 1'b0, 1'b1, 1'b0, "bad_f7");
  endtask

  task automatic test_decimation();
    sendFrame(1'b1, -1, 1'b0, 1'b1, 1'b0, "decim_f8");
  endtask

  task automatic test_reset_mid();
    mAddrA = 0; mAddrB = 0;
    idle(3);
    // only the first 4 pixels leave the pipeline before reset hits
    sendLine(0, 6, 1'b1, 1'b0, 4);
    @(negedge clk);
    rst = 1'b1; de = 1'b0; d = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    checksTotal++;
    if (enA !== 1'b0 || enB !== 1'b0) $display("[TB] FAIL rstmid_en: got A=%b B=%b required 0", enA, enB);
    else checksPassed++;
    checksTotal++;
    if (lockA !== 1'b0 || lockB !== 1'b0) $display("[TB] FAIL rstmid_lock: got A=%b B=%b required 0", lockA, lockB);
    else checksPassed++;
    checksTotal++;
    if (qA.size() != 0 || qB.size() != 0) $display("[TB] FAIL rstmid_pending: A=%0d B=%0d required 0", qA.size(), qB.size());
    else checksPassed++;
    idle(4);
    sendFrame(1'b0, -1, 1'b0, 1'b0, 1'b0, "relock_f1");
    sendFrame(1'b0, -1, 1'b0, 1'b0, 1'b0, "relock_f2");
    sendFrame(1'b0, -1, 1'b0, 1'b1, 1'b0, "relock_f3");
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_lock_acquire();
    test_capture();
    test_bad_line();
    test_decimation();
    test_reset_mid();
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
